// File: rtl/if_prefetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   IF_RESET_PC : default first fetch address after reset
//   INST_NOP    : instruction word presented while nothing is valid
//   IF_ENTRY_W  : width of one buffered entry ({pc, inst})
//   if_entry_t  : packed {pc, inst} entry stored in the prefetch FIFO
//   word_align  : clears the byte-offset bits of an address
package if_prefetch_pkg;

  localparam logic [31:0] IF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] INST_NOP    = 32'h0000_0000;
  localparam int          IF_ENTRY_W  = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_prefetch_sync_fifo.sv
// sync_fifo: small single-clock FIFO, kept generic so other buffers can reuse it.
//   clk, rst : clock and synchronous active-high reset
//   push/din : write din when push=1 and not full
//   pop      : drop the head entry when pop=1 and not empty
//   clear    : empty the FIFO at the next edge (takes priority over push/pop)
//   dout     : head entry (valid only while empty=0)
//   full, empty, count : occupancy status (count is clog2(DEPTH)+1 bits)
// DEPTH must be a power of two so the pointers wrap for free.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  input  logic                     clear,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] entry_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign dout    = entry_q[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage is only a handful of entries, so each one is its own register
  // with a read mux; contents need no reset because empty gates them.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_reg == PTR_W'(gi))) entry_reg <= din;
      end
      assign entry_q[gi] = entry_reg;
    end
  endgenerate

endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: instruction-fetch front end ahead of the decode/execute core.
// Prefetches sequential words over a req/gnt/rvalid bus, buffers {pc, inst}
// in an in-order FIFO and hands them to decode with valid/ready. A redirect
// flushes the FIFO, restarts fetch at the new PC and drops responses that
// belong to requests granted before it.
//   clk, rst                 : clock, synchronous active-high reset
//   redirect, redirect_pc    : flush and restart fetch at redirect_pc (bits [1:0] ignored)
//   mem_req, mem_addr        : fetch request and its word address
//   mem_gnt                  : request accepted this cycle
//   mem_rvalid, mem_rdata    : in-order response word
//   inst_valid, inst, inst_pc: instruction for decode
//   inst_ready               : decode accepts inst this cycle
// Build option IF_PREFETCH_BYPASS_EN: a response arriving into an empty FIFO is
// shown to decode in the same cycle (and not stored if decode takes it).
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int          OUT_W    = $clog2(MAX_OUT) + 1;
  localparam int          CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [31:0] START_PC = word_align(RESET_PC);

  logic [31:0]      fetch_pc_reg;
  logic [31:0]      resp_pc_reg;
  logic [OUT_W-1:0] outstanding_reg;
  logic [OUT_W-1:0] outstanding_next;
  logic [OUT_W-1:0] discard_reg;
  logic [31:0]      new_pc;

  logic             grant;
  logic             rvalid_ok;
  logic             drop_resp;
  logic             keep_resp;
  logic             bypass;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  if_entry_t        fifo_head;
  if_entry_t        push_entry;

  assign new_pc   = word_align(redirect_pc);
  assign mem_addr = fetch_pc_reg;

  // Only issue when both the bus window and the FIFO have room for the answer,
  // so a response can never find the FIFO full.
  assign mem_req = !rst && !redirect
                   && (int'(outstanding_reg) < MAX_OUT)
                   && (int'(fifo_count) + int'(outstanding_reg) < DEPTH);

  assign grant     = mem_req && mem_gnt;
  // A response with nothing outstanding is a bus error; it is ignored.
  assign rvalid_ok = mem_rvalid && (outstanding_reg != '0);
  assign drop_resp = rvalid_ok && (discard_reg != '0);
  // A response in the redirect cycle belongs to the old stream as well.
  assign keep_resp = rvalid_ok && (discard_reg == '0) && !redirect;

  assign outstanding_next = outstanding_reg + OUT_W'(grant) - OUT_W'(rvalid_ok);

`ifdef IF_PREFETCH_BYPASS_EN
  assign bypass = keep_resp && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign push_entry = '{pc: resp_pc_reg, inst: mem_rdata};
  assign fifo_push  = keep_resp && !(bypass && inst_ready);
  assign fifo_pop   = inst_ready && !fifo_empty;

  sync_fifo #(
    .WIDTH (IF_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (push_entry),
    .pop   (fifo_pop),
    .clear (redirect),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // With nothing to show, inst_pc tracks the next PC expected back from memory.
  always_comb begin
    inst_valid = !fifo_empty || bypass;
    inst       = INST_NOP;
    inst_pc    = resp_pc_reg;
    if (!fifo_empty) begin
      inst    = fifo_head.inst;
      inst_pc = fifo_head.pc;
    end else if (bypass) begin
      inst = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg    <= START_PC;
      resp_pc_reg     <= START_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
      if (redirect) begin
        fetch_pc_reg <= new_pc;
        resp_pc_reg  <= new_pc;
        // Every request still in flight after this cycle is stale. Older stale
        // requests are already part of outstanding, so this is the accumulated
        // discard count of back-to-back redirects.
        discard_reg  <= outstanding_next;
      end else begin
        if (grant)     fetch_pc_reg <= fetch_pc_reg + 32'd4;
        if (keep_resp) resp_pc_reg  <= resp_pc_reg + 32'd4;
        if (drop_resp) discard_reg  <= discard_reg - 1'b1;
      end
    end
  end

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
    !(mem_rvalid && (outstanding_reg == '0)));

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && fifo_full));

endmodule

// File: tb/tb_if_prefetch.sv
module tb_if_prefetch;

  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
`ifdef IF_PREFETCH_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;

  always #5 clk = ~clk;

  if_prefetch #(
    .DEPTH    (DEPTH),
    .MAX_OUT  (MAX_OUT),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
  );

  // Memory side: granted requests waiting for an answer, tagged with the
  // fetch stream (epoch) they belong to.
  typedef struct { logic [31:0] addr; int epoch; } pend_t;
  // Scoreboard: instructions decode must see, with the cycle they arrived.
  typedef struct { logic [31:0] pc; logic [31:0] inst; int cyc; } exp_t;

  pend_t       pend[$];
  exp_t        exp_q[$];
  int          cyc = 0;
  int          epoch = 0;
  int          pend_start = 0;
  logic [31:0] model_resp_pc = RESET_PC;
  logic [31:0] exp_fetch = RESET_PC;
  bit          post_rst = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_9E11;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // One bus cycle: drive inputs after the edge, then play the memory's part.
  task automatic step(input bit g, input bit rv, input bit rdy, input bit rdir,
                      input logic [31:0] rpc, input bit r);
    pend_t e;
    @(posedge clk);
    #1;
    cyc         = cyc + 1;
    rst         = r;
    redirect    = rdir && !r;
    redirect_pc = rpc;
    mem_gnt     = g;
    inst_ready  = rdy;
    mem_rvalid  = rv && !r && (pend.size() > 0);
    mem_rdata   = mem_rvalid ? mem_word(pend[0].addr) : 32'($urandom);
    pend_start  = pend.size();
    #1;
    if (r) begin
      pend.delete();
      model_resp_pc = RESET_PC;
      epoch++;
    end else begin
      if (mem_rvalid) begin
        e = pend.pop_front();
        if (e.epoch == epoch && !redirect) begin
          exp_q.push_back('{pc: model_resp_pc, inst: mem_word(model_resp_pc), cyc: cyc});
          model_resp_pc = model_resp_pc + 32'd4;
        end
      end
      if (mem_req && mem_gnt) pend.push_back('{addr: mem_addr, epoch: epoch});
      if (redirect) begin
        epoch++;
        model_resp_pc = rpc & 32'hFFFF_FFFC;
      end
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard once per cycle.
  int mon_buf;
  bit mon_req;
  bit mon_valid;

  always @(negedge clk) begin
    if (rst) begin
      chk("req_in_reset", {31'b0, mem_req}, 32'd0);
      exp_q.delete();
      exp_fetch = RESET_PC;
      post_rst  = 1'b1;
    end else begin
      if (post_rst) begin
        chk("reset_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("reset_inst", inst, 32'd0);
        chk("reset_inst_pc", inst_pc, RESET_PC);
        chk("reset_mem_addr", mem_addr, RESET_PC);
        post_rst = 1'b0;
      end
      mon_buf = 0;
      foreach (exp_q[i]) if (exp_q[i].cyc < cyc) mon_buf++;
      mon_req = !redirect && (pend_start < MAX_OUT) && (mon_buf + pend_start < DEPTH);
      chk("mem_req", {31'b0, mem_req}, {31'b0, mon_req});
      if (mem_req) begin
        chk("mem_addr", mem_addr, exp_fetch);
        if (mem_gnt) exp_fetch = exp_fetch + 32'd4;
      end
      mon_valid = (exp_q.size() > 0) && (exp_q[0].cyc + LAT <= cyc);
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, mon_valid});
      if (mon_valid && inst_valid) begin
        chk("inst_pc", inst_pc, exp_q[0].pc);
        chk("inst", inst, exp_q[0].inst);
      end
      if (mon_valid && inst_ready) begin
        $display("cycle %0d: decode took pc=%h inst=%h", cyc, inst_pc, inst);
        void'(exp_q.pop_front());
      end
      if (redirect) begin
        exp_q.delete();
        exp_fetch = redirect_pc & 32'hFFFF_FFFC;
      end
    end
  end

  initial begin
    int          n;
    logic [31:0] rpc;
    // Reset
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 32'h0, 1);
    // Streaming with immediate grants and one-cycle responses
    for (int i = 0; i < 40; i++) step(1, 1, 1, 0, 32'h0, 0);
    // Decode stalled: FIFO fills to DEPTH, then requests stop
    for (int i = 0; i < 15; i++) step(1, 1, 0, 0, 32'h0, 0);
    for (int i = 0; i < 8; i++)  step(1, 1, 1, 0, 32'h0, 0);
    // Two unanswered grants, then redirect to an unaligned target
    n = 0;
    while (pend.size() < 2 && n < 20) begin
      step(1, 0, 1, 0, 32'h0, 0);
      n++;
    end
    chk("two_outstanding", pend.size(), 32'd2);
    step(1, 0, 1, 1, 32'h0040_0102, 0);
    for (int i = 0; i < 12; i++) step(1, 1, 1, 0, 32'h0, 0);
    // Buffered words plus redirect coinciding with grant and response
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 32'h0, 0);
    step(1, 1, 0, 1, 32'h0000_8000, 0);
    for (int i = 0; i < 12; i++) step(1, 1, 1, 0, 32'h0, 0);
    // Address wrap
    step(1, 0, 1, 1, 32'hFFFF_FFFC, 0);
    for (int i = 0; i < 12; i++) step(1, 1, 1, 0, 32'h0, 0);
    // Randomized traffic with redirects and occasional resets
    for (int i = 0; i < 1500; i++) begin
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                         : 32'($urandom);
      step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
           $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 4,
           rpc, $urandom_range(0, 999) < 5);
    end
    // Drain
    for (int i = 0; i < 20; i++) step(0, 1, 1, 0, 32'h0, 0);
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
